// File: rtl/max_exp_pkg.sv
// Shared widths and tree-node type for the max-exponent reduction unit.
// MAX_EXP_ARGMAX_EN adds a lane-index field to every tree node.
package max_exp_pkg;

    localparam int unsigned CFG_DATA_WIDTH  = 6;
    localparam int unsigned CFG_NUM_IN      = 16;
    localparam int unsigned CFG_GROUP_BEATS = 4;

    function automatic int unsigned tree_depth(input int unsigned num_in);
        return $clog2(num_in);
    endfunction

    function automatic int unsigned lane_idx_w(input int unsigned num_in);
        return (num_in <= 2) ? 1 : $clog2(num_in);
    endfunction

    // Zero when a group is a single beat.
    function automatic int unsigned beat_idx_w(input int unsigned group_beats);
        return $clog2(group_beats);
    endfunction

    function automatic int unsigned beats_w(input int unsigned group_beats);
        return $clog2(group_beats + 1);
    endfunction

    localparam int unsigned EXP_W  = CFG_DATA_WIDTH;
    localparam int unsigned LANE_W = lane_idx_w(CFG_NUM_IN);

    typedef struct packed {
        logic [EXP_W-1:0]  exp;
`ifdef MAX_EXP_ARGMAX_EN
        logic [LANE_W-1:0] idx;
`endif
    } node_t;

endpackage

// File: rtl/max_exp_level.sv
// One registered comparator level: M nodes in, M/2 pairwise maxima out.
// Ties keep the lower (even) operand so the lower lane index wins.
module max_exp_level
    import max_exp_pkg::*;
#(
    parameter int unsigned M = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in_valid,
    input  logic              in_last,
    input  node_t [M-1:0]     in_node,
    output logic              out_valid,
    output logic              out_last,
    output node_t [M/2-1:0]   out_node
);

    node_t [M/2-1:0] max_c;

    always_comb begin
        max_c = '0;
        for (int j = 0; j < int'(M / 2); j++) begin
            max_c[j] = (in_node[2*j+1].exp > in_node[2*j].exp) ? in_node[2*j+1] : in_node[2*j];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_node  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_last  <= in_last;
            out_node  <= max_c;
        end
    end

endmodule

// File: rtl/max_exp_reduce.sv
// Pipelined max-exponent reduction: comparator tree, per-group accumulator, output register.
// Define MAX_EXP_ARGMAX_EN to report the {beat, lane} position of the maximum on out_idx.
module max_exp_reduce
    import max_exp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = CFG_DATA_WIDTH,
    parameter int unsigned NUM_IN      = CFG_NUM_IN,
    parameter int unsigned GROUP_BEATS = CFG_GROUP_BEATS
) (
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic                                                    in_valid,
    output logic                                                    in_ready,
    input  logic [NUM_IN*DATA_WIDTH-1:0]                            in_exp,
    input  logic                                                    in_last,
    output logic                                                    out_valid,
    input  logic                                                    out_ready,
    output logic [DATA_WIDTH-1:0]                                   out_exp,
    output logic [beats_w(GROUP_BEATS)-1:0]                         out_beats,
    output logic [tree_depth(NUM_IN)+beat_idx_w(GROUP_BEATS)-1:0]   out_idx
);

    localparam int unsigned L     = tree_depth(NUM_IN);
    localparam int unsigned CNT_W = beats_w(GROUP_BEATS);
    localparam int unsigned NODES = 2 * NUM_IN - 1;

    // All tree levels packed back to back: level k starts at 2*NUM_IN - 2*(NUM_IN>>k).
    node_t [NODES-1:0] nodes;
    logic  [L:0]       vld;
    logic  [L:0]       lst;
    logic              en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign vld[0]   = in_valid;
    assign lst[0]   = in_last;

    for (genvar i = 0; i < int'(NUM_IN); i++) begin : g_lane
        assign nodes[i].exp = in_exp[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef MAX_EXP_ARGMAX_EN
        assign nodes[i].idx = LANE_W'(i);
`endif
    end

    for (genvar k = 0; k < int'(L); k++) begin : g_lvl
        localparam int unsigned M       = NUM_IN >> k;
        localparam int unsigned OFF_IN  = 2 * NUM_IN - 2 * M;
        localparam int unsigned OFF_OUT = 2 * NUM_IN - M;
        max_exp_level #(.M(M)) u_level (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .in_valid  (vld[k]),
            .in_last   (lst[k]),
            .in_node   (nodes[OFF_IN +: M]),
            .out_valid (vld[k+1]),
            .out_last  (lst[k+1]),
            .out_node  (nodes[OFF_OUT +: M/2])
        );
    end

    node_t                  tree_c;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_WIDTH-1:0]  run_exp;
    logic [DATA_WIDTH-1:0]  next_exp_c;
    logic                   take_c;
    logic                   close_c;
    logic                   beat_c;

    assign tree_c     = nodes[NODES-1];
    assign beat_c     = en && vld[L];
    // First beat of a group always loads; later beats must be strictly greater.
    assign take_c     = (cnt == '0) || (tree_c.exp > run_exp);
    assign close_c    = lst[L] || (cnt == CNT_W'(GROUP_BEATS - 1));
    assign next_exp_c = take_c ? tree_c.exp : run_exp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            run_exp   <= '0;
            out_valid <= 1'b0;
            out_exp   <= '0;
            out_beats <= '0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (beat_c) begin
                run_exp <= next_exp_c;
                if (close_c) begin
                    out_valid <= 1'b1;
                    out_exp   <= next_exp_c;
                    out_beats <= cnt + CNT_W'(1);
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef MAX_EXP_ARGMAX_EN
    localparam int unsigned BW    = beat_idx_w(GROUP_BEATS);
    localparam int unsigned IDX_W = L + BW;

    logic [IDX_W-1:0] run_idx;
    logic [IDX_W-1:0] win_idx_c;
    logic [IDX_W-1:0] next_idx_c;

    if (BW > 0) begin : g_beat_idx
        assign win_idx_c = {cnt[BW-1:0], tree_c.idx};
    end else begin : g_no_beat_idx
        assign win_idx_c = tree_c.idx;
    end

    assign next_idx_c = take_c ? win_idx_c : run_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_idx <= '0;
            out_idx <= '0;
        end else if (beat_c) begin
            run_idx <= next_idx_c;
            if (close_c) begin
                out_idx <= next_idx_c;
            end
        end
    end
`else
    assign out_idx = '0;
`endif

endmodule

// File: tb/tb_max_exp_reduce.sv
// Directed and randomized bench for max_exp_reduce against a group-level reference model.
module tb_max_exp_reduce;

    localparam int W       = 6;
    localparam int N       = 16;
    localparam int G       = 4;
    localparam int BEATS_W = 3;
    localparam int IDX_W   = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [N*W-1:0]    in_exp;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_exp;
    logic [BEATS_W-1:0] out_beats;
    logic [IDX_W-1:0]  out_idx;

    always #5 clk = ~clk;

    max_exp_reduce #(.DATA_WIDTH(W), .NUM_IN(N), .GROUP_BEATS(G)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_exp    (in_exp),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_exp   (out_exp),
        .out_beats (out_beats),
        .out_idx   (out_idx)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: open group state plus queue of finished groups.
    int q_exp[$];
    int q_beats[$];
    int q_idx[$];
    int g_cnt = 0;
    int g_max = 0;
    int g_idx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Scan beat-major, lane-minor; strict > keeps the first occurrence of the maximum.
    task automatic model_beat(input logic [N*W-1:0] b, input logic last);
        for (int l = 0; l < N; l++) begin
            int v;
            v = int'(b[l*W +: W]);
            if ((g_cnt == 0 && l == 0) || v > g_max) begin
                g_max = v;
                g_idx = g_cnt * N + l;
            end
        end
        g_cnt++;
        if (last || g_cnt == G) begin
            q_exp.push_back(g_max);
            q_beats.push_back(g_cnt);
            q_idx.push_back(g_idx);
            g_cnt = 0;
        end
    endtask

    function automatic logic [N*W-1:0] rand_beat(input int lo, input int hi);
        logic [N*W-1:0] b;
        b = '0;
        for (int l = 0; l < N; l++) b[l*W +: W] = W'($urandom_range(hi, lo));
        return b;
    endfunction

    // Lanes strictly below m except lane `lane`, which holds m.
    function automatic logic [N*W-1:0] beat_with(input int m, input int lane);
        logic [N*W-1:0] b;
        b = '0;
        for (int l = 0; l < N; l++) if (m > 0) b[l*W +: W] = W'($urandom_range(m - 1, 0));
        b[lane*W +: W] = W'(m);
        return b;
    endfunction

    // One cycle: drive at the falling edge, observe handshakes, advance to the next falling edge.
    task automatic step(input logic v, input logic last, input logic [N*W-1:0] b,
                        input logic rdy, output logic acc);
        int e_idx;
        in_valid  = v;
        in_last   = last;
        in_exp    = b;
        out_ready = rdy;
        #1;
        acc = v && in_ready;
        if (out_valid && out_ready) begin
            check("output_expected", 32'(q_exp.size() > 0), 1);
            if (q_exp.size() > 0) begin
                check("out_exp", 32'(out_exp), q_exp.pop_front());
                check("out_beats", 32'(out_beats), q_beats.pop_front());
                e_idx = q_idx.pop_front();
`ifndef MAX_EXP_ARGMAX_EN
                e_idx = 0;
`endif
                check("out_idx", 32'(out_idx), e_idx);
            end
        end
        if (acc) model_beat(b, last);
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        for (int c = 0; c < 12; c++) step(1'b0, 1'b0, '0, 1'b1, acc);
        check("drained", q_exp.size(), 0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_exp    = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        g_cnt = 0;
        q_exp.delete();
        q_beats.delete();
        q_idx.delete();
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_exp", 32'(out_exp), 0);
        check("rst_out_beats", 32'(out_beats), 0);
        check("rst_out_idx", 32'(out_idx), 0);
        check("rst_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        logic           acc;
        logic           lastv;
        logic [N*W-1:0] b;
        logic [N*W-1:0] beats[4];

        do_reset();

        // Four-beat group with maxima 5,12,12,3; winner at beat 1 lane 7, five-cycle latency.
        beats[0] = beat_with(5, 11);
        beats[1] = beat_with(12, 7);
        beats[2] = beat_with(12, 2);
        beats[3] = beat_with(3, 0);
        for (int i = 0; i < 4; i++) step(1'b1, i == 3, beats[i], 1'b1, acc);
        check("grp1_model_exp", q_exp[0], 12);
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b0;
            #1;
            check("latency_out_valid", 32'(out_valid), 32'(k == 5));
            step(1'b0, 1'b0, '0, 1'b1, acc);
        end
        drain();

        // Single beat, all lanes equal: lane 0 wins the tie.
        b = '0;
        for (int l = 0; l < N; l++) b[l*W +: W] = W'(9);
        step(1'b1, 1'b1, b, 1'b1, acc);
        drain();

        // 63 versus 0: unsigned comparison must pick 63.
        b = rand_beat(0, 1);
        for (int l = 0; l < N; l++) b[l*W +: W] = (b[l*W] == 1'b1) ? W'(63) : W'(0);
        b[0 +: W] = '0;
        b[9*W +: W] = W'(63);
        step(1'b1, 1'b0, b, 1'b1, acc);
        step(1'b1, 1'b1, '0, 1'b1, acc);
        b = '0;
        b[15*W +: W] = W'(63);
        step(1'b1, 1'b1, b, 1'b1, acc);
        drain();

        // Back-to-back single-beat groups: one result per cycle once the pipe is full.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b0;
            #1;
            if (i >= 5) check("b2b_out_valid", 32'(out_valid), 1);
            step(1'b1, 1'b1, rand_beat(0, 63), 1'b1, acc);
        end
        drain();

        // Backpressure: out_ready low with continuous input, then release.
        do_reset();
        b = rand_beat(0, 63);
        for (int c = 0; c < 16; c++) begin
            if (c >= 9) begin
                in_valid  = 1'b1;
                in_last   = 1'b0;
                in_exp    = b;
                out_ready = 1'b0;
                #1;
                check("stall_in_ready", 32'(in_ready), 0);
                check("stall_out_valid", 32'(out_valid), 1);
                check("stall_hold_exp", 32'(out_exp), q_exp[0]);
            end
            step(1'b1, 1'b0, b, 1'b0, acc);
            if (acc) b = rand_beat(0, 63);
        end
        lastv = 1'b0;
        for (int c = 0; c < 24; c++) begin
            step(1'b1, lastv, b, 1'b1, acc);
            if (acc) begin
                b = rand_beat(0, 63);
                lastv = ($urandom_range(3, 0) == 0);
            end
        end
        step(1'b1, 1'b1, b, 1'b1, acc);
        drain();

        // Reset mid-group discards the partial group (max 60); next group reports only its own max.
        step(1'b1, 1'b0, beat_with(60, 3), 1'b1, acc);
        step(1'b1, 1'b0, beat_with(60, 4), 1'b1, acc);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, beat_with((i == 2) ? 40 : 20, 5), 1'b1, acc);
        check("post_reset_model_beats", q_beats[0], 4);
        drain();

        // Randomized traffic with random valid, ready and early closes.
        b = rand_beat(0, 63);
        lastv = 1'b0;
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(4, 0) != 0), lastv, b, ($urandom_range(3, 0) != 0), acc);
            if (acc) begin
                b = ($urandom_range(1, 0) == 1) ? rand_beat(0, 63) : rand_beat(0, 15);
                lastv = ($urandom_range(3, 0) == 0);
            end
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/max_exp_reduce.md
# max_exp_reduce

Pipelined, parametrised max-exponent reduction unit for block-floating-point grouping in the PE datapath. Each beat carries NUM_IN unsigned exponents. A registered comparator tree reduces them, and an accumulator stage tracks the running maximum across up to GROUP_BEATS beats per group. It emits one shared exponent per group under a valid/ready handshake and sits between the exponent extractor and the mantissa-alignment shifters.

## Interface
- DATA_WIDTH, 6: exponent width, unsigned.
- NUM_IN, 16: lanes per beat. Power of two, ≥2.
- GROUP_BEATS, 4: maximum beats per group. ≥1.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_exp  input  NUM_IN×DATA_WIDTH  lane exponents; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  input  1  closes the group early on this beat.
- out_valid  output  1  group result valid.
- out_ready  input  1  downstream accept.
- out_exp  output  DATA_WIDTH  group maximum exponent.
- out_beats  output  $clog2(GROUP_BEATS+1)  number of beats in the group.
- out_idx  output  $clog2(NUM_IN)+$clog2(GROUP_BEATS)  argmax position as {beat, lane}. Driven 0 without MAX_EXP_ARGMAX_EN. The beat field has width 0 when GROUP_BEATS=1.

## Operation
- Let L = $clog2(NUM_IN).
- Tree: L comparator levels, each registered. Comparison is unsigned. Strictly-greater selects the upper operand, so ties resolve to the lower lane index.
- Accumulator: holds running max, running idx and beat counter cnt, which starts at 0.
  - On a tree-output beat, if cnt==0, load that beat's value. Otherwise replace the running max only if the beat's value is strictly greater, so ties resolve to the earlier beat.
- Group close: the beat carries in_last, or cnt==GROUP_BEATS-1.
  - On close, the final max, idx and beat count (cnt+1) load into the output register, out_valid is set, and cnt returns to 0.
  - Otherwise cnt increments.
- in_last travels down the pipeline alongside each beat.
- Global advance enable: en = !out_valid || out_ready.
  - in_ready = en.
  - All tree stages, the accumulator and per-stage valid bits move only when en is high.
  - Pipeline bubbles (stage valid=0) do not touch the accumulator.
- out_valid clears on out_ready unless a new group closes in the same cycle. In that case the output is reloaded and out_valid stays 1, so back-to-back groups run without a bubble.
- Output fields hold stable while out_valid && !out_ready.

## Timing
- Reset values: all stage valid bits 0, cnt 0, running max and idx 0, out_valid 0, out_exp 0, out_beats 0, out_idx 0. in_ready is 1 after reset, since out_valid is 0.
- Latency: a closing beat accepted in cycle t produces out_valid=1 in cycle t+L+1 when there is no stall.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, the whole pipe freezes and in_ready=0. No beat is dropped or duplicated.
- GROUP_BEATS=1: every beat closes a group, and out_beats=1.
- in_last on the first beat of a group gives out_beats=1.
- Reset asserted mid-group discards the partial group and all in-flight beats. No output is produced for them.

## Configuration
- MAX_EXP_ARGMAX_EN defined:
  - Each tree stage carries a lane-index field alongside the exponent.
  - The accumulator records {beat, lane} of the winning element, and out_idx reports it using the tie rules above.
- Not defined:
  - Index registers and index muxes are not generated.
  - out_idx is tied to 0.
  - Exponent, handshake and latency are identical to the defined case.

## Structure
- Package max_exp_pkg holds:
  - The localparams/functions for tree depth, lane-index width, beat-index width and out_beats width.
  - A packed struct for a tree node, {exp, idx}, with idx present only under MAX_EXP_ARGMAX_EN.
- Sub-module max_exp_level: one registered comparator level with width-parametrised pairwise max over M inputs to M/2 outputs. It has an enable input and a valid bit, and is instantiated L times via generate.
- The top level contains the accumulator, beat counter, output register and handshake.

## Test plan
- NUM_IN=16, GROUP_BEATS=4, out_ready=1. Four beats with maxima 5, 12, 12, 3, max in lane 7 of beat 1 → out_exp=12, out_beats=4, out_idx={1,7} (ARGMAX), out_valid exactly at cycle t_last+5.
- All lanes equal to 9 in one beat with in_last=1 → out_exp=9, out_beats=1, out_idx=0.
- out_ready held 0 for 10 cycles after the first group, with continuous in_valid → in_ready=0 while stalled. After release, all subsequent groups arrive in order with correct values and none are lost.
- Back-to-back single-beat groups (in_last every beat) with out_ready=1 → one out_valid per cycle in steady state, out_exp matching each beat's max.
- Exponents 63 and 0 mixed (DATA_WIDTH=6) → out_exp=63, confirming unsigned comparison.
- reset pulsed after 2 of 4 beats → outputs return to reset values. The next full group reports only its own maximum, with out_beats=4.
